adc_scan_sequencer: RTL and testbench

Multi-channel scan controller for the AD7687 16-bit ADC front end. Selects an external analog multiplexer channel, waits a settling interval, and triggers the serial conversion reader. It then collects the 16-bit result, optionally averages several conversions, and stores one result per channel in a register bank the host reads by address. It sits between the host/control logic and the conversion reader, and it is the only block that requests conversions.

---
 rtl/adc_seq_pkg.sv | 12 +
 rtl/adc_seq_timer.sv | 34 +++
 rtl/adc_scan_sequencer.sv | 175 +++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and sizing helpers for the ADC scan sequencer.
package adc_seq_pkg;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_FIND, S_SETTLE, S_START, S_WAIT, S_ACC, S_STORE
    } seq_state_e;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/adc_seq_timer.sv
// Periodic scan trigger: counts while enabled, holds at reload while disabled,
// and emits a one-cycle pulse every PERIOD_CYC enabled cycles.
module adc_seq_timer #(
    parameter int PERIOD_CYC = 10000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);
    localparam int TW = $clog2(PERIOD_CYC + 1);

    logic [TW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (!i_en) begin
                r_cnt <= '0;
            end else if (r_cnt == TW'(PERIOD_CYC - 1)) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tick = r_tick;
endmodule

// File: rtl/adc_scan_sequencer.sv
// Multi-channel AD7687 scan controller with per-channel result bank.
// Define ADC_SEQ_AVG_EN to average 2^AVG_LOG2 conversions per channel.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SETTLE_CYC  = 32,
    parameter int PERIOD_CYC  = 10000,
    parameter int TIMEOUT_CYC = 64,
    parameter int AVG_LOG2    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_oneshot,
    input  logic [N_CH-1:0]         i_ch_mask,
    output logic [ch_w(N_CH)-1:0]   o_mux_sel,
    output logic                    o_conv_start,
    input  logic                    i_conv_done,
    input  logic [DATA_W-1:0]       i_conv_data,
    input  logic [ch_w(N_CH)-1:0]   i_rd_addr,
    output logic [DATA_W-1:0]       o_rd_data,
    output logic [N_CH-1:0]         o_new_flags,
    input  logic [N_CH-1:0]         i_clr_flags,
    output logic                    o_scan_busy,
    output logic                    o_scan_done,
    output logic                    o_overrun,
    output logic                    o_timeout_err
);
    localparam int CW = ch_w(N_CH);
    localparam int TW = $clog2(((SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC) + 1);

    seq_state_e        r_state, w_next;
    logic [N_CH-1:0]   r_pend, r_flags, w_set;
    logic [CW-1:0]     r_sel, w_ch;
    logic [TW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_sample, r_rd_data, w_result;
    logic [DATA_W-1:0] r_bank [N_CH];
    logic              r_done, r_ovr, r_terr;
    logic              w_tick, w_trig, w_found, w_timeout, w_last, w_conv_start;

    adc_seq_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_en   (i_en),
        .o_tick (w_tick)
    );

    assign w_trig    = w_tick | i_oneshot;
    assign w_timeout = (r_state == S_WAIT) && !i_conv_done && (r_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_set     = (r_state == S_STORE) ? (N_CH'(1) << r_sel) : '0;

`ifdef ADC_SEQ_AVG_EN
    localparam int AW  = DATA_W + AVG_LOG2;
    localparam int NSW = AVG_LOG2 + 1;
    logic [AW-1:0]  r_acc;
    logic [NSW-1:0] r_nsamp;

    assign w_last   = (r_nsamp == NSW'((1 << AVG_LOG2) - 1));
    assign w_result = DATA_W'(r_acc >> AVG_LOG2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_nsamp <= '0;
        end else if (r_state == S_ACC) begin
            r_acc   <= r_acc + AW'(r_sample);
            r_nsamp <= r_nsamp + 1'b1;
        end else if (r_state == S_STORE || w_timeout) begin
            r_acc   <= '0;
            r_nsamp <= '0;
        end
    end
`else
    assign w_last   = 1'b1;
    assign w_result = r_sample;
`endif

    // Lowest pending channel wins.
    always_comb begin
        w_found = 1'b0;
        w_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_found = 1'b1;
                w_ch    = CW'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_conv_start = 1'b0;
        case (r_state)
            S_IDLE:   if (w_trig) w_next = S_FIND;
            S_FIND:   w_next = w_found ? S_SETTLE : S_IDLE;
            S_SETTLE: if (r_cnt == TW'(SETTLE_CYC - 1)) w_next = S_START;
            S_START: begin
                w_conv_start = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (i_conv_done)    w_next = S_ACC;
                else if (w_timeout) w_next = S_FIND;
            end
            S_ACC:    w_next = w_last ? S_STORE : S_START;
            S_STORE:  w_next = S_FIND;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend   <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_sample <= '0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
            r_terr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_trig && r_state != S_IDLE) r_ovr <= 1'b1;
            case (r_state)
                S_IDLE: if (w_trig) r_pend <= i_ch_mask;
                S_FIND: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_sel        <= w_ch;
                        r_pend[w_ch] <= 1'b0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                S_SETTLE: r_cnt <= r_cnt + 1'b1;
                // WAIT counts from 1 so the timeout lands TIMEOUT_CYC after the START cycle.
                S_START:  r_cnt <= TW'(1);
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_conv_done)    r_sample <= i_conv_data;
                    else if (w_timeout) r_terr   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_CH; i++) r_bank[i] <= '0;
            r_flags   <= '0;
            r_rd_data <= '0;
        end else begin
            if (r_state == S_STORE) r_bank[r_sel] <= w_result;
            r_flags <= (r_flags & ~i_clr_flags) | w_set;
            // Forward the value being stored so a read of that address sees it next cycle.
            if (r_state == S_STORE && r_sel == i_rd_addr) r_rd_data <= w_result;
            else                                          r_rd_data <= r_bank[i_rd_addr];
        end
    end

    assign o_mux_sel     = r_sel;
    assign o_conv_start  = w_conv_start;
    assign o_rd_data     = r_rd_data;
    assign o_new_flags   = r_flags;
    assign o_scan_busy   = (r_state != S_IDLE);
    assign o_scan_done   = r_done;
    assign o_overrun     = r_ovr;
    assign o_timeout_err = r_terr;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: a timeline model built from the scan rules
// drives per-cycle expectations, plus directed literal checks per scenario.
module tb_adc_scan_sequencer;
    localparam int SET  = 32;
    localparam int PER  = 200;
    localparam int TMO  = 64;
    localparam int RSP  = 10;
    localparam int MAXC = 4000;
`ifdef ADC_SEQ_AVG_EN
    localparam int NS = 4;
    localparam int SH = 2;
`else
    localparam int NS = 1;
    localparam int SH = 0;
`endif

    logic        i_clk = 0, i_rst_n = 0, i_en = 0, i_oneshot = 0;
    logic [3:0]  i_ch_mask = 0, i_clr_flags = 0;
    logic [1:0]  i_rd_addr = 0;
    logic        i_conv_done = 0;
    logic [15:0] i_conv_data = 0;
    logic [1:0]  o_mux_sel;
    logic        o_conv_start, o_scan_busy, o_scan_done, o_overrun, o_timeout_err;
    logic [15:0] o_rd_data;
    logic [3:0]  o_new_flags;

    adc_scan_sequencer #(.N_CH(4), .SETTLE_CYC(SET), .PERIOD_CYC(PER),
                         .TIMEOUT_CYC(TMO), .AVG_LOG2(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_oneshot(i_oneshot),
        .i_ch_mask(i_ch_mask), .o_mux_sel(o_mux_sel), .o_conv_start(o_conv_start),
        .i_conv_done(i_conv_done), .i_conv_data(i_conv_data), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_new_flags(o_new_flags), .i_clr_flags(i_clr_flags),
        .o_scan_busy(o_scan_busy), .o_scan_done(o_scan_done), .o_overrun(o_overrun),
        .o_timeout_err(o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;
    bit exp_start[MAXC], exp_busy[MAXC], exp_done[MAXC], exp_muxv[MAXC];
    bit exp_terr_set[MAXC], exp_ovr_set[MAXC];
    int exp_mux[MAXC];
    logic [15:0] rvals[64];
    int pidx, ridx, silent_ch = 0, rdue = 0, n_starts = 0;
    bit silent_en = 0, rp = 0;
    logic [15:0] m_bank[4];
    logic [3:0]  m_flags = 0;
    int st_cyc[4];
    logic m_terr = 0, m_ovr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One cycle: advance past the edge, drop pulses, run the reader model.
    task automatic tick();
        @(posedge i_clk); #1;
        i_oneshot   = 0;
        i_clr_flags = 0;
        i_conv_done = 0;
        i_conv_data = 16'($urandom);
        if (o_conv_start) n_starts++;
        if (rp && cyc == rdue) begin
            i_conv_done = 1;
            i_conv_data = rvals[ridx];
            ridx++;
            rp = 0;
        end
        if (o_conv_start && !(silent_en && int'(o_mux_sel) == silent_ch)) begin
            rp   = 1;
            rdue = cyc + RSP;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic set_vals(input logic [15:0] v);
        for (int i = 0; i < 64; i++) rvals[i] = v;
        pidx = 0;
        ridx = 0;
    endtask

    task automatic clear_exp(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_start[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_muxv[c] = 0;
            exp_terr_set[c] = 0; exp_ovr_set[c] = 0; exp_mux[c] = 0;
        end
    endtask

    // Timeline of a scan triggered in cycle T, derived from the scan rules.
    task automatic plan_scan(input int T, input logic [3:0] mask, output int tend);
        int t, s, nxt, acc;
        t = T + 1;
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                s = t + 1 + SET;
                if (silent_en && ch == silent_ch) begin
                    exp_start[s] = 1;
                    exp_terr_set[s + TMO] = 1;
                    nxt = s + TMO;
                end else begin
                    acc = 0;
                    for (int k = 0; k < NS; k++) begin
                        exp_start[s] = 1;
                        acc += int'(rvals[pidx]);
                        pidx++;
                        if (k < NS - 1) s += RSP + 2;
                    end
                    st_cyc[ch]  = s + RSP + 2;
                    m_bank[ch]  = 16'(acc >> SH);
                    m_flags[ch] = 1;
                    nxt = s + RSP + 3;
                end
                for (int c = t + 1; c <= nxt; c++) begin
                    exp_muxv[c] = 1;
                    exp_mux[c]  = ch;
                end
                t = nxt;
            end
        end
        for (int c = T + 1; c <= t; c++) exp_busy[c] = 1;
        exp_done[t + 1] = 1;
        tend = t + 1;
    endtask

    task automatic fire(input logic [3:0] mask, output int tend);
        i_ch_mask = mask;
        i_oneshot = 1;
        plan_scan(cyc, mask, tend);
        tick();
        i_ch_mask = ~mask;
    endtask

    task automatic read_all(input string nm);
        for (int a = 0; a < 4; a++) begin
            i_rd_addr = 2'(a);
            tick();
            chk(nm, o_rd_data, m_bank[a]);
        end
    endtask

    always @(negedge i_clk) begin
        logic et, eo;
        if (!chk_en) begin
            m_terr <= 0;
            m_ovr  <= 0;
        end else if (cyc < MAXC) begin
            et = m_terr | exp_terr_set[cyc];
            eo = m_ovr | exp_ovr_set[cyc];
            chk("conv_start", o_conv_start, exp_start[cyc]);
            chk("scan_busy", o_scan_busy, exp_busy[cyc]);
            chk("scan_done", o_scan_done, exp_done[cyc]);
            chk("timeout_err", o_timeout_err, et);
            chk("overrun", o_overrun, eo);
            if (exp_muxv[cyc]) chk("mux_sel", o_mux_sel, exp_mux[cyc]);
            m_terr <= et;
            m_ovr  <= eo;
        end
    end

    initial begin
        int tend, T, got, E, s1;
        for (int i = 0; i < 4; i++) m_bank[i] = 0;

        repeat (3) tick();
        chk("rst_mux", o_mux_sel, 0);
        chk("rst_start", o_conv_start, 0);
        chk("rst_rd", o_rd_data, 0);
        chk("rst_flags", o_new_flags, 0);
        chk("rst_busy", o_scan_busy, 0);
        chk("rst_done", o_scan_done, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_terr", o_timeout_err, 0);
        i_rst_n = 1;
        tick();
        chk_en = 1;
        repeat (5) tick();

        // Two-channel scan, constant reader data.
        set_vals(16'h1234);
        n_starts = 0;
        fire(4'b0101, tend);
        wait_until(tend + 2);
        chk("A_starts", n_starts, 2 * NS);
        chk("A_flags", o_new_flags, 4'b0101);
        read_all("A_bank");
        i_rd_addr = 0; tick(); chk("A_bank0_lit", o_rd_data, 16'h1234);
        i_rd_addr = 2; tick(); chk("A_bank2_lit", o_rd_data, 16'h1234);
        i_clr_flags = 4'b1111; tick();
        m_flags = 0;
        chk("A_flags_clr", o_new_flags, 0);

        // Averaging: 100+101+102+104 = 407, 407>>2 = 101.
        set_vals(16'd0);
        rvals[0] = 16'd100; rvals[1] = 16'd101; rvals[2] = 16'd102; rvals[3] = 16'd104;
        n_starts = 0;
        fire(4'b0001, tend);
        wait_until(tend + 2);
        chk("B_starts", n_starts, NS);
        i_rd_addr = 0; tick();
`ifdef ADC_SEQ_AVG_EN
        chk("B_avg_lit", o_rd_data, 16'd101);
`else
        chk("B_avg_lit", o_rd_data, 16'd100);
`endif
        i_clr_flags = 4'b1111; tick();
        m_flags = 0;

        // Silent reader on channel 1: timeout, no store, continue to channel 2.
        set_vals(16'h0BEE);
        silent_en = 1;
        silent_ch = 1;
        fire(4'b0110, tend);
        wait_until(tend + 2);
        silent_en = 0;
        chk("C_terr_lit", o_timeout_err, 1);
        chk("C_flags", o_new_flags, 4'b0100);
        i_rd_addr = 1; tick(); chk("C_bank1_lit", o_rd_data, 16'h0000);
        i_rd_addr = 2; tick(); chk("C_bank2_lit", o_rd_data, 16'h0BEE);
        read_all("C_bank");
        i_clr_flags = 4'b1111; tick();
        m_flags = 0;

        // ONESHOT mid-scan: overrun, and no second scan follows.
        set_vals(16'h0777);
        fire(4'b0001, tend);
        repeat (20) tick();
        exp_ovr_set[cyc + 1] = exp_busy[cyc];
        i_oneshot = 1;
        wait_until(tend + 40);
        chk("D_ovr_lit", o_overrun, 1);

        // Empty mask completes without conversions.
        n_starts = 0;
        got = -1;
        T = cyc;
        fire(4'b0000, tend);
        for (int i = 0; i < 4; i++) begin
            if (o_scan_done && got < 0) got = cyc - T;
            tick();
        end
        chk("E_done_lat", got, 2);
        chk("E_starts", n_starts, 0);
        i_clr_flags = 4'b1111; tick();
        m_flags = 0;

        // Store on channel 3 coincides with its clear: set wins; read bypass.
        set_vals(16'h5A5A);
        i_rd_addr = 3;
        tick();
        fire(4'b1000, tend);
        wait_until(st_cyc[3]);
        chk("F_rd_before", o_rd_data, 16'h0000);
        i_clr_flags = 4'b1000;
        tick();
        chk("F_set_wins", o_new_flags, 4'b1000);
        chk("F_rd_bypass", o_rd_data, 16'h5A5A);
        wait_until(tend + 2);
        i_clr_flags = 4'b1000; tick();
        m_flags[3] = 0;
        chk("F_clr", o_new_flags, 0);

        // Period timer: first trigger PER cycles after EN rises.
        set_vals(16'h0042);
        i_ch_mask = 4'b0001;
        E = cyc;
        i_en = 1;
        plan_scan(E + PER, 4'b0001, tend);
        got = -1;
        while (cyc < E + PER + 100) begin
            tick();
            if (o_scan_busy && got < 0) got = cyc - E;
        end
        i_en = 0;
        chk("G_first_busy", got, PER + 1);
        wait_until(E + 2 * PER + 20);
        i_rd_addr = 0; tick(); chk("G_bank0_lit", o_rd_data, 16'h0042);
        i_clr_flags = 4'b1111; tick();
        m_flags = 0;

        // Reset asserted during WAIT.
        set_vals(16'h0999);
        T = cyc;
        fire(4'b1111, tend);
        s1 = T + 2 + SET;
        wait_until(s1 + 5);
        chk_en = 0;
        i_rst_n = 0;
        #1;
        chk("H_mux", o_mux_sel, 0);
        chk("H_start", o_conv_start, 0);
        chk("H_rd", o_rd_data, 0);
        chk("H_flags", o_new_flags, 0);
        chk("H_busy", o_scan_busy, 0);
        chk("H_done", o_scan_done, 0);
        chk("H_ovr", o_overrun, 0);
        chk("H_terr", o_timeout_err, 0);
        clear_exp(cyc);
        for (int i = 0; i < 4; i++) m_bank[i] = 0;
        m_flags = 0;
        #2 i_rst_n = 1;
        tick();
        chk_en = 1;
        repeat (20) tick();
        read_all("H_bank");
        i_rd_addr = 2; tick(); chk("H_bank2_lit", o_rd_data, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
